// File: rtl/shift_register_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_register_pkg
//  Description : Mode encodings shared by the universal shift register and
//                anything that drives it.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_register_pkg;

    localparam int unsigned c_MODE_W = 3;

    localparam logic [c_MODE_W-1:0] c_MODE_HOLD = 3'd0;
    localparam logic [c_MODE_W-1:0] c_MODE_SHL  = 3'd1;
    localparam logic [c_MODE_W-1:0] c_MODE_SHR  = 3'd2;
    localparam logic [c_MODE_W-1:0] c_MODE_LOAD = 3'd3;
    localparam logic [c_MODE_W-1:0] c_MODE_ROTL = 3'd4;
    localparam logic [c_MODE_W-1:0] c_MODE_ROTR = 3'd5;
    // Codes 6 and 7 are unused and behave as HOLD.

endpackage : shift_register_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Counter that saturates at MAX, with a registered flag that is
//                high exactly while the count sits at MAX. clear wins over inc.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         inc,
    output logic [$clog2(MAX+1)-1:0]     count,
    output logic                         done
);

    localparam int                 c_CNT_W = $clog2(MAX + 1);
    localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MAX);

    logic [c_CNT_W-1:0] r_count;
    logic               r_done;
    logic [c_CNT_W-1:0] w_next_count;

    // Next count: clear to zero, otherwise step up until MAX is reached
    always_comb begin
        w_next_count = r_count;
        if (clear) begin
            w_next_count = '0;
        end else if (inc && (r_count != c_MAX)) begin
            w_next_count = r_count + 1'b1;
        end
    end

    // Count and flag registered together so done tracks count on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_done  <= (w_next_count == c_MAX);
        end
    end

    assign count = r_count;
    assign done  = r_done;

endmodule : sat_counter
`default_nettype wire

// File: rtl/shift_register_universal.sv
`default_nettype none
// ============================================================================
//  Module      : shift_register_universal
//  Description : WIDTH-bit register with hold, shift left/right, parallel load
//                and rotate left/right, plus a saturating shift counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_register_universal
    import shift_register_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [2:0]                   mode,
    input  logic                         in,
    input  logic [WIDTH-1:0]             load_data,
    output logic [WIDTH-1:0]             out,
    output logic                         sout,
    output logic [$clog2(WIDTH+1)-1:0]   count,
    output logic                         done
);

    logic [WIDTH-1:0] r_out;
    logic             r_sout;
    logic [WIDTH-1:0] w_next_out;
    logic             w_next_sout;
    logic             w_shift;
    logic             w_load;

    // Decode the operation; anything not listed, or en low, holds state
    always_comb begin
        w_next_out  = r_out;
        w_next_sout = r_sout;
        w_shift     = 1'b0;
        w_load      = 1'b0;
        if (en) begin
            case (mode)
                c_MODE_SHL: begin
                    w_next_out  = {r_out[WIDTH-2:0], in};
                    w_next_sout = r_out[WIDTH-1];
                    w_shift     = 1'b1;
                end
                c_MODE_SHR: begin
                    w_next_out  = {in, r_out[WIDTH-1:1]};
                    w_next_sout = r_out[0];
                    w_shift     = 1'b1;
                end
                c_MODE_LOAD: begin
                    // sout deliberately keeps the last shifted-out bit
                    w_next_out  = load_data;
                    w_load      = 1'b1;
                end
                c_MODE_ROTL: begin
                    w_next_out  = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
                    w_next_sout = r_out[WIDTH-1];
                    w_shift     = 1'b1;
                end
                c_MODE_ROTR: begin
                    w_next_out  = {r_out[0], r_out[WIDTH-1:1]};
                    w_next_sout = r_out[0];
                    w_shift     = 1'b1;
                end
                c_MODE_HOLD: begin
                    w_next_out  = r_out;
                end
                default: begin
                    w_next_out  = r_out;
                end
            endcase
        end
    end

    // Data register and shift-out bit; reset overrides any operation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out  <= RESET_VALUE;
            r_sout <= 1'b0;
        end else begin
            r_out  <= w_next_out;
            r_sout <= w_next_sout;
        end
    end

    sat_counter #(
        .MAX   (WIDTH)
    ) u_sat_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (w_load),
        .inc   (w_shift),
        .count (count),
        .done  (done)
    );

    assign out  = r_out;
    assign sout = r_sout;

endmodule : shift_register_universal
`default_nettype wire
